// File: rtl/matmul_pkg.sv
// Shared types and default geometry for the sequenced 3-lane matrix multiplier.
// Index widths are derived with idx_w so that a dimension of one still gets a 1-bit counter.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int P_DEF  = 3;
    localparam int Q_DEF  = 3;
    localparam int S_DEF  = 3;
    localparam int L_DEF  = 3;
    localparam int DW_DEF = 8;
    localparam int RW_DEF = 18;

    localparam int NG  = S_DEF / L_DEF;
    localparam int A_N = P_DEF * Q_DEF;
    localparam int B_N = Q_DEF * S_DEF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = idx_w(P_DEF);
    localparam int COL_W = idx_w(S_DEF);

endpackage

// File: rtl/matmul_seq_if.sv
// Control, load-stream and result-stream signals of matmul_seq.
// The master side is the host/DMA plus result consumer; the slave side is the sequencer.
interface matmul_seq_if #(
    parameter int DW  = matmul_pkg::DW_DEF,
    parameter int RW  = matmul_pkg::RW_DEF,
    parameter int RIW = matmul_pkg::ROW_W,
    parameter int CIW = matmul_pkg::COL_W
);
    logic           start;
    logic           busy;
    logic           done;
    logic           a_valid;
    logic           a_ready;
    logic [DW-1:0]  a_data;
    logic           b_valid;
    logic           b_ready;
    logic [DW-1:0]  b_data;
    logic           c_valid;
    logic           c_ready;
    logic [RW-1:0]  c_data;
    logic [RIW-1:0] c_row;
    logic [CIW-1:0] c_col;

    modport master (
        output start, a_valid, a_data, b_valid, b_data, c_ready,
        input  busy, done, a_ready, b_ready, c_valid, c_data, c_row, c_col
    );

    modport slave (
        input  start, a_valid, a_data, b_valid, b_data, c_ready,
        output busy, done, a_ready, b_ready, c_valid, c_data, c_row, c_col
    );
endinterface

// File: rtl/matmul_mac_lane.sv
// One multiply-accumulate lane: unsigned DW x DW product, zero-extended and summed mod 2^RW.
// clr with en loads the product directly so a new block needs no separate clear cycle.
module matmul_mac_lane #(
    parameter int DW = 8,
    parameter int RW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] acc
);
    logic [2*DW-1:0] prod_s;
    logic [RW-1:0]   prod_ext_s;

    assign prod_s     = a * b;
    assign prod_ext_s = RW'(prod_s);

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= clr ? prod_ext_s : acc + prod_ext_s;
        end
    end
endmodule

// File: rtl/matmul_seq.sv
// Start/busy/done sequencer: loads A and B, runs L MAC lanes per column group, streams C row-major.
// Every block is Q accumulate cycles followed by L result beats.
module matmul_seq #(
    parameter int P  = matmul_pkg::P_DEF,
    parameter int Q  = matmul_pkg::Q_DEF,
    parameter int S  = matmul_pkg::S_DEF,
    parameter int L  = matmul_pkg::L_DEF,
    parameter int DW = matmul_pkg::DW_DEF,
    parameter int RW = matmul_pkg::RW_DEF
) (
    input logic         clk,
    input logic         rst,
    matmul_seq_if.slave bus
);
    import matmul_pkg::*;

    localparam int N_GRP = S / L;
    localparam int A_TOT = P * Q;
    localparam int B_TOT = Q * S;
    localparam int AW    = idx_w(A_TOT);
    localparam int BW    = idx_w(B_TOT);
    localparam int ACW   = $clog2(A_TOT + 1);
    localparam int BCW   = $clog2(B_TOT + 1);
    localparam int KW    = idx_w(Q);
    localparam int GW    = idx_w(N_GRP);
    localparam int LW    = idx_w(L);
    localparam int RIW   = idx_w(P);
    localparam int CIW   = idx_w(S);

    if (S % L != 0) begin : g_bad_lanes
        $error("matmul_seq: S must be a multiple of L");
    end

    state_t          state_r, state_nx;
    logic [ACW-1:0]  a_cnt_r, a_cnt_nx;
    logic [BCW-1:0]  b_cnt_r, b_cnt_nx;
    logic [KW-1:0]   k_r;
    logic [GW-1:0]   g_r;
    logic [LW-1:0]   l_r;
    logic [RIW-1:0]  i_r;
    logic [DW-1:0]   a_mem_r [A_TOT];
    logic [DW-1:0]   b_mem_r [B_TOT];
    logic            busy_r, done_r, a_ready_r, b_ready_r, c_valid_r;
    logic [RW-1:0]   acc_s   [L];
    logic [AW-1:0]   a_idx_s;
    logic [BW-1:0]   b_idx_s [L];
    logic [DW-1:0]   a_op_s;
    logic [DW-1:0]   b_op_s  [L];
    logic            a_hs_s, b_hs_s, c_hs_s, k_last_s, l_last_s, g_last_s, i_last_s;
    logic            mac_en_s, mac_clr_s;

    assign a_hs_s    = bus.a_valid & a_ready_r;
    assign b_hs_s    = bus.b_valid & b_ready_r;
    assign c_hs_s    = c_valid_r & bus.c_ready;
    assign k_last_s  = (k_r == KW'(Q - 1));
    assign l_last_s  = (l_r == LW'(L - 1));
    assign g_last_s  = (g_r == GW'(N_GRP - 1));
    assign i_last_s  = (i_r == RIW'(P - 1));
    assign mac_en_s  = (state_r == ST_MAC);
    assign mac_clr_s = (state_r == ST_MAC) && (k_r == KW'(0));

    // Load counts after this cycle's handshakes; IDLE clears them for the next run
    always_comb begin
        a_cnt_nx = a_cnt_r;
        b_cnt_nx = b_cnt_r;
        if (state_r == ST_IDLE) begin
            a_cnt_nx = '0;
            b_cnt_nx = '0;
        end else begin
            a_cnt_nx = a_hs_s ? a_cnt_r + ACW'(1) : a_cnt_r;
            b_cnt_nx = b_hs_s ? b_cnt_r + BCW'(1) : b_cnt_r;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: state_nx = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                if ((a_cnt_nx == ACW'(A_TOT)) && (b_cnt_nx == BCW'(B_TOT))) begin
                    state_nx = ST_MAC;
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            ST_MAC:  state_nx = k_last_s ? ST_OUT : ST_MAC;
            ST_OUT: begin
                if (c_hs_s && l_last_s) begin
                    state_nx = (g_last_s && i_last_s) ? ST_DONE : ST_MAC;
                end else begin
                    state_nx = ST_OUT;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx;
    end

    // Status and handshake flags, registered from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            a_ready_r <= 1'b0;
            b_ready_r <= 1'b0;
            c_valid_r <= 1'b0;
        end else begin
            busy_r    <= (state_nx == ST_LOAD) || (state_nx == ST_MAC) || (state_nx == ST_OUT);
            done_r    <= (state_nx == ST_DONE);
            a_ready_r <= (state_nx == ST_LOAD) && (a_cnt_nx < ACW'(A_TOT));
            b_ready_r <= (state_nx == ST_LOAD) && (b_cnt_nx < BCW'(B_TOT));
            c_valid_r <= (state_nx == ST_OUT);
        end
    end

    // Load, inner-product, lane, group and row counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_r <= '0;
            b_cnt_r <= '0;
            k_r     <= '0;
            g_r     <= '0;
            l_r     <= '0;
            i_r     <= '0;
        end else begin
            a_cnt_r <= a_cnt_nx;
            b_cnt_r <= b_cnt_nx;
            case (state_r)
                ST_IDLE: begin
                    k_r <= '0;
                    g_r <= '0;
                    l_r <= '0;
                    i_r <= '0;
                end
                ST_MAC:  k_r <= k_last_s ? KW'(0) : k_r + KW'(1);
                ST_OUT: begin
                    if (c_hs_s) begin
                        if (l_last_s) begin
                            l_r <= '0;
                            g_r <= g_last_s ? GW'(0) : g_r + GW'(1);
                            if (g_last_s) i_r <= i_last_s ? RIW'(0) : i_r + RIW'(1);
                        end else begin
                            l_r <= l_r + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand arrays; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (a_hs_s) a_mem_r[a_cnt_r[AW-1:0]] <= bus.a_data;
        if (b_hs_s) b_mem_r[b_cnt_r[BW-1:0]] <= bus.b_data;
    end

    // Operand fetch: one A element shared by all lanes, one B column per lane
    always_comb begin
        a_idx_s = AW'(int'(i_r) * Q + int'(k_r));
        a_op_s  = a_mem_r[a_idx_s];
        for (int l = 0; l < L; l++) begin
            b_idx_s[l] = BW'(int'(k_r) * S + int'(g_r) * L + l);
            b_op_s[l]  = b_mem_r[b_idx_s[l]];
        end
    end

    for (genvar l = 0; l < L; l++) begin : g_lane
        matmul_mac_lane #(.DW(DW), .RW(RW)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (mac_clr_s),
            .en  (mac_en_s),
            .a   (a_op_s),
            .b   (b_op_s[l]),
            .acc (acc_s[l])
        );
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.a_ready = a_ready_r;
    assign bus.b_ready = b_ready_r;
    assign bus.c_valid = c_valid_r;
    assign bus.c_data  = acc_s[l_r];
    assign bus.c_row   = i_r;
    assign bus.c_col   = CIW'(int'(g_r) * L + int'(l_r));
endmodule
